// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared state encoding, op codes and op classification
// helpers for the EX-stage multiply/divide unit.
// Op codes 4..7 (MADD/MADDU/MSUB/MSUBU) are only accepted when the
// accumulate feature is built in (MULDIV_ACC_EN).
package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic op_is_acc(input logic [2:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || op_is_sub(op);
  endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// ex_muldiv_div_iter: restoring divider, one quotient bit per step.
// Operands are unsigned magnitudes; sign handling lives in the parent.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_load            latch dividend/divisor and arm the step counter
//   i_step            perform one restoring step
//   i_dividend/i_divisor  unsigned operands
//   o_last            the step counter has reached its terminal count
//   o_quot/o_rem      quotient and remainder after DATA_W steps
module ex_muldiv_div_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_last,
  output logic [DATA_W-1:0] o_quot,
  output logic [DATA_W-1:0] o_rem
);
  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] r_quot, r_rem, r_div;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W:0]   w_shift, w_diff;
  logic              w_fit;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  assign w_shift = {r_rem, r_quot[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_fit   = ~w_diff[DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_quot <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= CNT_W'(DATA_W - 1);
    end else if (i_step) begin
      r_rem  <= w_fit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
      r_quot <= {r_quot[DATA_W-2:0], w_fit};
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last = (r_cnt == '0);
  assign o_quot = r_quot;
  assign o_rem  = r_rem;

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the EX stage (HI/LO results).
// Optional feature macro: MULDIV_ACC_EN (enables MADD/MADDU/MSUB/MSUBU).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start_i, op_i         request and op code, sampled only in IDLE
//   opdata1_i/opdata2_i   rs/rt operands
//   hi_i/lo_i             forwarded HI/LO, used only by accumulate ops
//   cancel_i              flush: abort to IDLE without a result pulse
//   stallreq_o            stall request toward pipeline control
//   ready_o, result_o     one-cycle result pulse and {HI,LO}
//
// state   | meaning
// IDLE    | waiting for a legal start
// MUL     | retiring MUL_BITS multiplier bits per cycle
// DIV     | restoring divide, one quotient bit per cycle
// DONE    | sign/accumulate correction, result pulse
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [2:0]          op_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic [DATA_W-1:0]   hi_i,
  input  logic [DATA_W-1:0]   lo_i,
  input  logic                cancel_i,
  output logic                stallreq_o,
  output logic                ready_o,
  output logic [2*DATA_W-1:0] result_o
);
  localparam int N_MUL = DATA_W / MUL_BITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_mcand, r_prod, r_result;
  logic [DATA_W-1:0]   r_mplier, r_dbz_hi;
  logic                r_is_div, r_dbz, r_neg_xor, r_neg_a;

  logic                w_legal, w_accept, w_s1, w_s2, w_div_last, w_dbz;
  logic [DATA_W-1:0]   w_mag1, w_mag2, w_quot, w_rem;
  logic [2*DATA_W-1:0] w_pp, w_prod_s, w_div_res, w_mul_res, w_final;

`ifdef MULDIV_ACC_EN
  logic [2*DATA_W-1:0] r_acc;
  logic                r_is_acc, r_is_sub;

  assign w_legal = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_is_acc <= 1'b0;
      r_is_sub <= 1'b0;
    end else if (w_accept) begin
      r_acc    <= {hi_i, lo_i};
      r_is_acc <= op_is_acc(op_i);
      r_is_sub <= op_is_sub(op_i);
    end
  end

  assign w_mul_res = !r_is_acc ? w_prod_s :
                     r_is_sub  ? (r_acc - w_prod_s) : (r_acc + w_prod_s);
`else
  logic w_unused_acc;
  assign w_unused_acc = ^{hi_i, lo_i};
  assign w_legal      = !op_i[2];
  assign w_mul_res    = w_prod_s;
`endif

  assign w_accept   = (r_state == ST_IDLE) && start_i && w_legal && !cancel_i;
  assign stallreq_o = w_accept || (r_state == ST_MUL) || (r_state == ST_DIV);
  assign w_dbz      = op_is_div(op_i) && (opdata2_i == '0);

  assign w_s1   = op_is_signed(op_i) & opdata1_i[DATA_W-1];
  assign w_s2   = op_is_signed(op_i) & opdata2_i[DATA_W-1];
  // Two's-complement negation of the most negative value yields the same bit
  // pattern, which is exactly its unsigned magnitude.
  assign w_mag1 = w_s1 ? -opdata1_i : opdata1_i;
  assign w_mag2 = w_s2 ? -opdata2_i : opdata2_i;

  always_comb begin
    w_pp = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (r_mplier[i]) w_pp = w_pp + (r_mcand << i);
    end
  end

  ex_muldiv_div_iter #(.DATA_W(DATA_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept && op_is_div(op_i) && !w_dbz),
    .i_step     ((r_state == ST_DIV) && !cancel_i),
    .i_dividend (w_mag1),
    .i_divisor  (w_mag2),
    .o_last     (w_div_last),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  assign w_prod_s  = r_neg_xor ? -r_prod : r_prod;
  // Divide by zero reports the raw dividend in HI, bypassing sign handling.
  assign w_div_res = r_dbz ? {r_dbz_hi, {DATA_W{1'b1}}} :
                     {(r_neg_a ? -w_rem : w_rem), (r_neg_xor ? -w_quot : w_quot)};
  assign w_final   = r_is_div ? w_div_res : w_mul_res;

  assign ready_o  = (r_state == ST_DONE) && !cancel_i;
  assign result_o = ready_o ? w_final : r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_prod    <= '0;
      r_result  <= '0;
      r_mplier  <= '0;
      r_dbz_hi  <= '0;
      r_is_div  <= 1'b0;
      r_dbz     <= 1'b0;
      r_neg_xor <= 1'b0;
      r_neg_a   <= 1'b0;
    end else if (cancel_i) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_div  <= op_is_div(op_i);
            r_dbz     <= w_dbz;
            r_dbz_hi  <= opdata1_i;
            r_neg_xor <= w_s1 ^ w_s2;
            r_neg_a   <= w_s1;
            r_mcand   <= {{DATA_W{1'b0}}, w_mag1};
            r_mplier  <= w_mag2;
            r_prod    <= '0;
            r_cnt     <= CNT_W'(N_MUL - 1);
            if (op_is_div(op_i)) r_state <= w_dbz ? ST_DONE : ST_DIV;
            else                 r_state <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_prod   <= r_prod + w_pp;
          r_mcand  <= r_mcand << MUL_BITS;
          r_mplier <= r_mplier >> MUL_BITS;
          if (r_cnt == '0) r_state <= ST_DONE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        ST_DIV: begin
          if (w_div_last) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_result <= w_final;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: the driver pushes the expected {HI,LO} and
// the cycle in which ready_o must appear; a monitor pops on every ready_o.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        cancel_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0, hi_i = '0, lo_i = '0;
  logic        stallreq_o, ready_o;
  logic [63:0] result_o;

  ex_muldiv #(.DATA_W(32), .MUL_BITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .cancel_i   (cancel_i),
    .stallreq_o (stallreq_o),
    .ready_o    (ready_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  bit   tb_done = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on 64-bit integers.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                        input logic [31:0] hi, lo);
    longint sa, sb_, sp;
    logic [63:0] up;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    sp  = sa * sb_;
    up  = 64'(a) * 64'(b);
    case (op)
      3'd0: return 64'(sp);
      3'd1: return up;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(sa % sb_), 32'(sa / sb_)};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return {hi, lo} + 64'(sp);
      3'd5: return {hi, lo} + up;
      3'd6: return {hi, lo} - 64'(sp);
      default: return {hi, lo} - up;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [31:0] b);
    if ((op == 3'd2 || op == 3'd3) && b == 0) return 1;
    if (op == 3'd2 || op == 3'd3) return 33;
    return 17;
  endfunction

  always @(negedge clk) begin
    if (!tb_done) begin
      if (ready_o) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_ready: got result %h at cycle %0d, expected no pulse", result_o, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("result", result_o, mon_e.res);
          chk("ready_cycle", 64'(cyc), 64'(mon_e.due));
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        mon_e = sb.pop_front();
        errors++;
        checks++;
        $display("FAIL ready_timeout: no ready_o by cycle %0d, expected at cycle %0d", cyc, mon_e.due);
      end
    end
  end

  // Called at posedge+1 of an idle cycle; returns at posedge+1 of an idle cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, hi, lo, input bit spurious);
    int c, lat;
    exp_t e;
    c = cyc;
    lat = latency(op, b);
    start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b; hi_i = hi; lo_i = lo;
    e.res = model(op, a, b, hi, lo);
    e.due = c + lat;
    sb.push_back(e);
    @(negedge clk);
    chk("stall_issue", 64'(stallreq_o), 64'(1));
    @(posedge clk); #1;
    start_i = 1'b0;
    opdata1_i = $urandom; opdata2_i = $urandom; hi_i = $urandom; lo_i = $urandom;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("stall_busy", 64'(stallreq_o), 64'(k < lat));
      @(posedge clk); #1;
      start_i = spurious && (k == 2) && (lat > 3);
      op_i = 3'($urandom_range(0, 3));
    end
    start_i = 1'b0;
  endtask

  task automatic abort_test(input bit use_rst);
    start_i = 1'b1; op_i = 3'd2; opdata1_i = 32'd1000; opdata2_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1;
    else cancel_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cancel_i = 1'b0;
    @(negedge clk);
    chk(use_rst ? "rst_abort_stall" : "cancel_abort_stall", 64'(stallreq_o), 64'(0));
    if (use_rst) chk("rst_abort_result_cleared", result_o, 64'(0));
    @(posedge clk); #1;
    issue(3'd1, 32'd3, 32'd3, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 64'(ready_o), 64'(0));
    chk("reset_result", result_o, 64'(0));
    chk("reset_stall", 64'(stallreq_o), 64'(0));
    @(posedge clk); #1;

    issue(3'd1, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0);
    issue(3'd0, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 1'b0);
    issue(3'd1, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 1'b1);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
    issue(3'd3, 32'h0000_1234, 32'd0, 32'd0, 32'd0, 1'b0);
    issue(3'd2, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, 1'b0);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 1'b0);

`ifdef MULDIV_ACC_EN
    issue(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
    issue(3'd6, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0);
`else
    start_i = 1'b1; op_i = 3'd4; opdata1_i = 32'd1; opdata2_i = 32'd1;
    @(negedge clk);
    chk("reserved_op_stall", 64'(stallreq_o), 64'(0));
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
`endif

    // start together with cancel in IDLE must be ignored
    start_i = 1'b1; cancel_i = 1'b1; op_i = 3'd1; opdata1_i = 32'd2; opdata2_i = 32'd2;
    @(negedge clk);
    chk("start_cancel_stall", 64'(stallreq_o), 64'(0));
    @(posedge clk); #1;
    start_i = 1'b0; cancel_i = 1'b0;
    @(negedge clk);
    chk("start_cancel_idle", 64'(stallreq_o), 64'(0));
    @(posedge clk); #1;

    abort_test(1'b0);
    abort_test(1'b1);

    for (int n = 0; n < 40; n++) begin
      r_op = 3'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: begin r_a = $urandom_range(0, 20); r_b = $urandom_range(0, 20); end
        1: begin r_a = $urandom; r_b = 32'd0; end
        2: begin r_a = $urandom; r_b = 32'hFFFF_FFFF - $urandom_range(0, 3); end
        default: begin r_a = $urandom; r_b = $urandom; end
      endcase
      issue(r_op, r_a, r_b, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    tb_done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
